xif_result_queue: RTL and testbench
===================================

XIF_RESULT_QUEUE -- requirements
Module: xif_result_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of result entries (power of two, >=2).
REQ-002 Parameter ID_WIDTH, default 4, XIF instruction id width.
REQ-003 Parameter DATA_WIDTH, default 32, result data width.
REQ-004 clk_i  in  1  single clock; all state updates on rising edge.
REQ-005 rst_ni  in  1  reset, synchronous, active-low.
REQ-006 push_valid_i  in  1  kronos result available; push_ready_o  out  1  queue accepts it.
REQ-007 push_id_i  in  ID_WIDTH; push_data_i  in  DATA_WIDTH; push_we_i  in  1  register-file write-back required.
REQ-008 commit_valid_i  in  1; commit_id_i  in  ID_WIDTH; commit_kill_i  in  1  XIF commit/kill of an offloaded id.
REQ-009 result_valid_o  out  1; result_ready_i  in  1  XIF result handshake towards the core.
REQ-010 result_id_o  out  ID_WIDTH; result_data_o  out  DATA_WIDTH; result_we_o  out  1.
REQ-011 count_o  out  clog2(DEPTH)+1  occupied entries; empty_o  out  1; full_o  out  1.

Function
REQ-012 Queue SHALL be in-order FIFO; transfer on push_valid_i && push_ready_o; push_ready_o = !full_o.
REQ-013 Status bitmaps committed[2^ID_WIDTH] and killed[2^ID_WIDTH] SHALL record commit_valid_i per id; kill sets killed, otherwise sets committed.
REQ-014 Commit for an id may arrive before, with, or after its push; same-cycle commit and push of one id SHALL be treated as already committed.
REQ-015 Head entry SHALL be presented (result_valid_o=1) only when its id is committed and not killed.
REQ-016 Head whose id is killed SHALL be discarded in one cycle without asserting result_valid_o.
REQ-017 Head uncommitted and not killed: result_valid_o=0; queue stalls; no reordering.
REQ-018 On pop (handshake or kill-discard), committed/killed bits for that id SHALL clear the same edge.
REQ-019 Once asserted, result_valid_o and payload SHALL stay stable until result_ready_i.
REQ-020 Simultaneous push and pop when full SHALL be rejected (push_ready_o depends on full only); when neither full nor empty both occur, count unchanged.
REQ-021 Pointers wrap modulo DEPTH; full/empty from extra pointer MSB.
REQ-022 Latency push-to-result_valid_o: 1 cycle if committed and queue empty (without bypass).
REQ-023 Commit for an id already in flight twice (re-use before pop) is a protocol error; behaviour unspecified, flagged by bench assertion.

Reset
REQ-024 While rst_ni=0 at clock edge: pointers, count_o=0, empty_o=1, full_o=0, result_valid_o=0, bitmaps cleared; result_id_o/result_data_o/result_we_o=0.
REQ-025 Reset mid-operation SHALL drop all entries and commit state; no result emitted in the cycle after release.

Configuration
REQ-026 Macro XIF_RESULT_BYPASS_EN defined: when queue empty and push id committed (including same cycle), result presented combinationally same cycle; if result_ready_i=1 entry not stored.
REQ-027 Without XIF_RESULT_BYPASS_EN: every result passes through storage; minimum latency 1 cycle.

Structure
REQ-028 Shared package kronos_pkg SHALL hold result entry struct (id, data, we) and default ID/DATA width constants.
REQ-029 One sub-module xif_result_fifo_mem (storage + pointers) is natural; status bitmaps stay in top.

Verification
REQ-030 Commit id 3 then push id 3 data 0xDEADBEEF, ready=1 -> result_valid_o next cycle, id 3, data 0xDEADBEEF, count returns 0.
REQ-031 Push ids 1,2 uncommitted; commit 2 -> no output; commit 1 -> outputs id 1 then id 2 in order.
REQ-032 Push ids 5,6; kill 5, commit 6 -> id 5 discarded silently, single result id 6.
REQ-033 Fill 4 entries, result_ready_i=0 -> full_o=1, push_ready_o=0, result payload stable across 10 cycles.
REQ-034 Reset asserted with 3 entries queued -> count_o=0, result_valid_o=0, later push of id reused needs fresh commit.
REQ-035 With XIF_RESULT_BYPASS_EN, empty queue, same-cycle push+commit id 7, ready=1 -> result_valid_o same cycle, count_o stays 0.

Source files
------------

// File: rtl/kronos_pkg.sv
// kronos_pkg: shared types and default widths for the XIF result path.
// The entry struct is sized by the default id/data widths.
package kronos_pkg;

  localparam int XIF_ID_W   = 4;
  localparam int XIF_DATA_W = 32;

  typedef struct packed {
    logic [XIF_ID_W-1:0]   id;
    logic [XIF_DATA_W-1:0] data;
    logic                  we;
  } xif_res_t;

  localparam int XIF_RES_W = $bits(xif_res_t);

endpackage

// File: rtl/xif_result_fifo_mem.sv
// xif_result_fifo_mem: in-order entry storage with wrap-around pointers.
// Full/empty come from the extra pointer MSB.
module xif_result_fifo_mem
  import kronos_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = XIF_RES_W,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rd_en_i,
  output logic [W-1:0] rd_data_o,
  output logic [AW:0]  count_o,
  output logic         empty_o,
  output logic         full_o
);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic         w_wr;
  logic         w_rd;

  assign empty_o = (r_wptr == r_rptr);
  assign full_o  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign count_o = r_wptr - r_rptr;
  assign w_wr    = wr_en_i && !full_o;
  assign w_rd    = rd_en_i && !empty_o;
  assign rd_data_o = r_mem[r_rptr[AW-1:0]];

  // pointer update; reset drops every entry
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

  // entry write; contents are don't-care until pointed at
  always_ff @(posedge clk_i) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/xif_result_queue.sv
// xif_result_queue: in-order XIF result FIFO gated by commit/kill state.
// Optional macro XIF_RESULT_BYPASS_EN: same-cycle bypass when empty.
module xif_result_queue
  import kronos_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ID_WIDTH   = XIF_ID_W,
  parameter int DATA_WIDTH = XIF_DATA_W
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_valid_i,
  output logic                  push_ready_o,
  input  logic [ID_WIDTH-1:0]   push_id_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  push_we_i,
  input  logic                  commit_valid_i,
  input  logic [ID_WIDTH-1:0]   commit_id_i,
  input  logic                  commit_kill_i,
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  output logic [ID_WIDTH-1:0]   result_id_o,
  output logic [DATA_WIDTH-1:0] result_data_o,
  output logic                  result_we_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                  empty_o,
  output logic                  full_o
);

  localparam int NID = 1 << ID_WIDTH;
  localparam int EW  = ID_WIDTH + DATA_WIDTH + 1;

  logic [NID-1:0]        r_committed;
  logic [NID-1:0]        r_killed;
  logic [NID-1:0]        w_cmt_nxt;
  logic [NID-1:0]        w_kil_nxt;
  logic [EW-1:0]         w_head;
  logic [EW-1:0]         w_push_ent;
  logic [EW-1:0]         w_out;
  logic [ID_WIDTH-1:0]   w_head_id;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_head_ok;
  logic                  w_head_kill;
  logic                  w_byp;
  logic                  w_byp_take;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_cmt_push;

  assign w_push_ent = {push_id_i, push_data_i, push_we_i};
  assign w_head_id  = w_head[EW-1 -: ID_WIDTH];
  assign w_push     = push_valid_i && !w_full;
  assign w_cmt_push = commit_valid_i && !commit_kill_i &&
                      (commit_id_i == push_id_i);

  assign w_head_ok   = !w_empty && r_committed[w_head_id] &&
                       !r_killed[w_head_id];
  assign w_head_kill = !w_empty && r_killed[w_head_id];

`ifdef XIF_RESULT_BYPASS_EN
  assign w_byp = w_empty && push_valid_i && !r_killed[push_id_i] &&
                 (r_committed[push_id_i] || w_cmt_push);
`else
  assign w_byp = 1'b0;
`endif

  assign w_byp_take = w_byp && result_ready_i;
  assign w_pop = (w_head_ok && result_ready_i) || w_head_kill;

  xif_result_fifo_mem #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_mem (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .wr_en_i   (w_push && !w_byp_take),
    .wr_data_i (w_push_ent),
    .rd_en_i   (w_pop),
    .rd_data_o (w_head),
    .count_o   (count_o),
    .empty_o   (w_empty),
    .full_o    (w_full)
  );

  assign empty_o      = w_empty;
  assign full_o       = w_full;
  assign push_ready_o = !w_full;

  assign result_valid_o = w_head_ok || w_byp;
  assign w_out = w_head_ok ? w_head :
                 (w_byp ? w_push_ent : '0);
  assign result_id_o   = w_out[EW-1 -: ID_WIDTH];
  assign result_data_o = w_out[DATA_WIDTH:1];
  assign result_we_o   = w_out[0];

  // next status bitmaps: clear on pop, then record new commit/kill
  always_comb begin
    w_cmt_nxt = r_committed;
    w_kil_nxt = r_killed;
    if (w_pop) begin
      w_cmt_nxt[w_head_id] = 1'b0;
      w_kil_nxt[w_head_id] = 1'b0;
    end
    if (w_byp_take) begin
      w_cmt_nxt[push_id_i] = 1'b0;
      w_kil_nxt[push_id_i] = 1'b0;
    end
    if (commit_valid_i && !(w_byp_take && w_cmt_push)) begin
      if (commit_kill_i) w_kil_nxt[commit_id_i] = 1'b1;
      else               w_cmt_nxt[commit_id_i] = 1'b1;
    end
  end

  // status bitmap registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_committed <= '0;
      r_killed    <= '0;
    end else begin
      r_committed <= w_cmt_nxt;
      r_killed    <= w_kil_nxt;
    end
  end

endmodule

// File: tb/tb_xif_result_queue.sv
// tb_xif_result_queue: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_xif_result_queue;
  import kronos_pkg::*;

  localparam int DEPTH = 4;
  localparam int IDW   = XIF_ID_W;
  localparam int DW    = XIF_DATA_W;
`ifdef XIF_RESULT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_ni;
  logic           push_valid_i;
  logic           push_ready_o;
  logic [IDW-1:0] push_id_i;
  logic [DW-1:0]  push_data_i;
  logic           push_we_i;
  logic           commit_valid_i;
  logic [IDW-1:0] commit_id_i;
  logic           commit_kill_i;
  logic           result_valid_o;
  logic           result_ready_i;
  logic [IDW-1:0] result_id_o;
  logic [DW-1:0]  result_data_o;
  logic           result_we_o;
  logic [$clog2(DEPTH):0] count_o;
  logic           empty_o;
  logic           full_o;

  xif_result_queue #(
    .DEPTH(DEPTH), .ID_WIDTH(IDW), .DATA_WIDTH(DW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .push_valid_i(push_valid_i), .push_ready_o(push_ready_o),
    .push_id_i(push_id_i), .push_data_i(push_data_i),
    .push_we_i(push_we_i),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i),
    .commit_kill_i(commit_kill_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_id_o(result_id_o), .result_data_o(result_data_o),
    .result_we_o(result_we_o),
    .count_o(count_o), .empty_o(empty_o), .full_o(full_o)
  );

  int n_vec = 0;
  int n_err = 0;

  xif_res_t mq[$];
  bit       mc[16];
  bit       mk[16];
  bit       p_hold;
  xif_res_t p_pl;

  task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic idle_in();
    push_valid_i   = 1'b0;
    push_id_i      = '0;
    push_data_i    = '0;
    push_we_i      = 1'b0;
    commit_valid_i = 1'b0;
    commit_id_i    = '0;
    commit_kill_i  = 1'b0;
    result_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_ni = 1'b0;
    idle_in();
    @(posedge clk);
    #1;
    chk("rst_count", count_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_valid", result_valid_o, 0);
    chk("rst_payload", {result_id_o, result_data_o, result_we_o}, 0);
    mq.delete();
    for (int i = 0; i < 16; i++) begin
      mc[i] = 1'b0;
      mk[i] = 1'b0;
    end
    p_hold = 1'b0;
    rst_ni = 1'b1;
  endtask

  task automatic cyc(bit pv, logic [3:0] pid, logic [31:0] pd, bit pwe,
                     bit cv, logic [3:0] cid, bit ck, bit rdy);
    xif_res_t pe, hd, ep;
    bit hok, hkill, byp, ev, pop, take, acc;
    int sz;
    @(negedge clk);
    push_valid_i   = pv;
    push_id_i      = pid;
    push_data_i    = pd;
    push_we_i      = pwe;
    commit_valid_i = cv;
    commit_id_i    = cid;
    commit_kill_i  = ck;
    result_ready_i = rdy;
    #1;
    sz = mq.size();
    pe = '{id: pid, data: pd, we: pwe};
    hd = '0;
    hok = 1'b0;
    hkill = 1'b0;
    if (sz > 0) begin
      hd = mq[0];
      hok = mc[hd.id] && !mk[hd.id];
      hkill = mk[hd.id];
    end
    byp = BYP && sz == 0 && pv && !mk[pid] &&
          (mc[pid] || (cv && !ck && cid == pid));
    ev = hok || byp;
    ep = hok ? hd : (byp ? pe : '0);
    if (cv) assert (!(mc[cid] || mk[cid]))
      else $error("protocol: id %0d committed twice in flight", cid);
    chk("count", count_o, sz);
    chk("empty", empty_o, sz == 0);
    chk("full", full_o, sz == DEPTH);
    chk("push_ready", push_ready_o, sz < DEPTH);
    chk("valid", result_valid_o, ev);
    chk("payload", {result_id_o, result_data_o, result_we_o}, ep);
    if (p_hold) begin
      chk("hold_valid", result_valid_o, 1);
      chk("hold_payload", {result_id_o, result_data_o, result_we_o}, p_pl);
    end
    p_hold = ev && !rdy;
    p_pl = ep;
    pop = (hok && rdy) || hkill;
    take = byp && rdy;
    acc = pv && sz < DEPTH;
    @(posedge clk);
    if (pop) begin
      mc[hd.id] = 1'b0;
      mk[hd.id] = 1'b0;
      void'(mq.pop_front());
    end
    if (acc && !take) mq.push_back(pe);
    if (take) begin
      mc[pid] = 1'b0;
      mk[pid] = 1'b0;
    end
    if (cv && !(take && cid == pid)) begin
      if (ck) mk[cid] = 1'b1;
      else    mc[cid] = 1'b1;
    end
  endtask

  task automatic nop(bit rdy);
    cyc(0, 0, 0, 0, 0, 0, 0, rdy);
  endtask

  initial begin
    rst_ni = 1'b0;
    idle_in();
    p_hold = 1'b0;
    do_reset();

    // commit before push
    cyc(0, 0, 0, 0, 1, 3, 0, 1);
    cyc(1, 3, 32'hDEADBEEF, 1, 0, 0, 0, 1);
    nop(1);
    nop(1);

    // in-order release after out-of-order commits
    cyc(1, 1, 32'h11, 1, 0, 0, 0, 1);
    cyc(1, 2, 32'h22, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 2, 0, 1);
    nop(1);
    nop(1);
    cyc(0, 0, 0, 0, 1, 1, 0, 1);
    for (int i = 0; i < 3; i++) nop(1);

    // killed head discarded silently
    cyc(1, 5, 32'h55, 1, 0, 0, 0, 1);
    cyc(1, 6, 32'h66, 1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 5, 1, 1);
    cyc(0, 0, 0, 0, 1, 6, 0, 1);
    for (int i = 0; i < 3; i++) nop(1);

    // fill, stall, stable payload, push rejected
    cyc(1, 8, 32'h8888, 1, 1, 8, 0, 0);
    cyc(1, 9, 32'h9999, 0, 0, 0, 0, 0);
    cyc(1, 10, 32'hAAAA, 1, 0, 0, 0, 0);
    cyc(1, 11, 32'hBBBB, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 12, 32'hC, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 9, 0, 1);
    cyc(0, 0, 0, 0, 1, 10, 0, 1);
    cyc(0, 0, 0, 0, 1, 11, 0, 1);
    for (int i = 0; i < 3; i++) nop(1);

    // reset with three entries queued
    cyc(1, 1, 32'h1, 1, 0, 0, 0, 1);
    cyc(1, 2, 32'h2, 1, 0, 0, 0, 1);
    cyc(1, 3, 32'h3, 1, 1, 1, 0, 0);
    do_reset();
    nop(1);
    cyc(1, 1, 32'h1F, 1, 0, 0, 0, 1);
    nop(1);
    nop(1);
    cyc(0, 0, 0, 0, 1, 1, 0, 1);
    nop(1);
    nop(1);

    // same-cycle push and commit on empty queue
    cyc(1, 7, 32'h7777, 1, 1, 7, 0, 1);
    nop(1);
    nop(1);

    // random traffic under protocol rules
    do_reset();
    for (int n = 0; n < 600; n++) begin
      bit pv, cv, ck, rdy;
      logic [3:0] pid, cid;
      bit inq[16];
      for (int i = 0; i < 16; i++) inq[i] = 1'b0;
      foreach (mq[i]) inq[mq[i].id] = 1'b1;
      pv = ($urandom_range(0, 2) != 0);
      pid = '0;
      if (pv) begin
        pv = 1'b0;
        for (int t = 0; t < 64 && !pv; t++) begin
          pid = 4'($urandom_range(0, 15));
          pv = !inq[pid];
        end
      end
      cv = ($urandom_range(0, 1) != 0);
      cid = '0;
      if (cv) begin
        if (pv && !(mc[pid] || mk[pid]) && $urandom_range(0, 3) == 0) begin
          cid = pid;
        end else begin
          cv = 1'b0;
          for (int t = 0; t < 64 && !cv; t++) begin
            cid = 4'($urandom_range(0, 15));
            cv = !(mc[cid] || mk[cid]);
          end
        end
      end
      ck = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      cyc(pv, pid, $urandom, 1'($urandom), cv, cid, ck, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
